// File: rtl/mmc_pkg.sv
// mmc_pkg: shared constants for the SPI-mode MMC/SD card responder.
//   Command indices, R1 bit values, data tokens, FSM state encoding and
//   the R1 response function.
package mmc_pkg;

   localparam logic [5:0] CMD0  = 6'd0;
   localparam logic [5:0] CMD1  = 6'd1;
   localparam logic [5:0] CMD16 = 6'd16;
   localparam logic [5:0] CMD17 = 6'd17;
   localparam logic [5:0] CMD24 = 6'd24;

   localparam logic [7:0] R1_READY   = 8'h00;
   localparam logic [7:0] R1_IDLE    = 8'h01;
   localparam logic [7:0] R1_ILLEGAL = 8'h04;
   localparam logic [7:0] R1_PARAM   = 8'h40;

   localparam logic [7:0] TOKEN_START    = 8'hFE;
   localparam logic [7:0] TOKEN_DATA_ACC = 8'h05;
   localparam logic [7:0] BYTE_FILL      = 8'hFF;
   localparam logic [7:0] BYTE_BUSY      = 8'h00;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_CMD      = 4'd1,
      S_NCR      = 4'd2,
      S_R1       = 4'd3,
      S_RD_TOKEN = 4'd4,
      S_RD_DATA  = 4'd5,
      S_RD_CRC   = 4'd6,
      S_WR_WAIT  = 4'd7,
      S_WR_DATA  = 4'd8,
      S_WR_CRC   = 4'd9,
      S_WR_RESP  = 4'd10,
      S_WR_BUSY  = 4'd11
   } state_t;

   function automatic logic [7:0] calc_r1(input logic [5:0]  cmd,
                                          input logic [31:0] arg,
                                          input logic        idle,
                                          input logic [31:0] blk_len);
      logic [7:0] r;
      case (cmd)
         CMD0:         r = R1_IDLE;
         CMD1:         r = R1_READY;
         CMD16:        r = (arg == blk_len) ? R1_READY : R1_PARAM;
         CMD17, CMD24: r = idle ? (R1_ILLEGAL | R1_IDLE) : R1_READY;
         default:      r = idle ? (R1_ILLEGAL | R1_IDLE) : R1_ILLEGAL;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mmc_card_spi_if.sv
// mmc_card_spi_if: SPI link and backing-store port of the card responder.
//   mmc_cs/mmc_sclk/mmc_do from host, mmc_di to host; byte-wide memory
//   port (mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata); debug card_idle and
//   state_out. slave = card side, master = host/memory side.
interface mmc_card_spi_if;
   logic        mmc_cs;
   logic        mmc_sclk;
   logic        mmc_do;
   logic        mmc_di;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        card_idle;
   logic [3:0]  state_out;

   modport slave (
      input  mmc_cs, mmc_sclk, mmc_do, mem_rdata,
      output mmc_di, mem_addr, mem_rd, mem_wr, mem_wdata, card_idle, state_out
   );

   modport master (
      output mmc_cs, mmc_sclk, mmc_do, mem_rdata,
      input  mmc_di, mem_addr, mem_rd, mem_wr, mem_wdata, card_idle, state_out
   );
endinterface

// File: rtl/mmc_spi_byte.sv
// mmc_spi_byte: SPI mode-0 byte engine, card side.
//   Inputs : clk, reset, mmc_cs/mmc_sclk/mmc_do (async to clk), tx_load/tx_byte.
//   Outputs: mmc_di, cs_active (synchronized select), byte_done (8th rising
//            edge seen), rx_byte (valid while byte_done is high).
module mmc_spi_byte (
   input  logic       clk,
   input  logic       reset,
   input  logic       mmc_cs,
   input  logic       mmc_sclk,
   input  logic       mmc_do,
   input  logic       tx_load,
   input  logic [7:0] tx_byte,
   output logic       mmc_di,
   output logic       cs_active,
   output logic       byte_done,
   output logic [7:0] rx_byte
);
   logic       cs_s1_q, cs_s2_q;
   logic       sclk_s1_q, sclk_s2_q, sclk_prev_q;
   logic       do_s1_q, do_s2_q;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d;
   logic       miso_q, miso_d;
   logic       rise, fall;

   // MOSI goes through the same two stages as SCLK so both stay aligned
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_s1_q     <= 1'b1;
         cs_s2_q     <= 1'b1;
         sclk_s1_q   <= 1'b0;
         sclk_s2_q   <= 1'b0;
         sclk_prev_q <= 1'b0;
         do_s1_q     <= 1'b0;
         do_s2_q     <= 1'b0;
         bit_cnt_q   <= 3'd0;
         rx_q        <= 7'd0;
         tx_q        <= 8'hFF;
         miso_q      <= 1'b1;
      end else begin
         cs_s1_q     <= mmc_cs;
         cs_s2_q     <= cs_s1_q;
         sclk_s1_q   <= mmc_sclk;
         sclk_s2_q   <= sclk_s1_q;
         sclk_prev_q <= sclk_s2_q;
         do_s1_q     <= mmc_do;
         do_s2_q     <= do_s1_q;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         miso_q      <= miso_d;
      end
   end

   assign cs_active = ~cs_s2_q;
   assign rise      = cs_active &  sclk_s2_q & ~sclk_prev_q;
   assign fall      = cs_active & ~sclk_s2_q &  sclk_prev_q;
   assign byte_done = rise & (bit_cnt_q == 3'd7);
   assign rx_byte   = {rx_q, do_s2_q};
   assign mmc_di    = miso_q;

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      miso_d    = miso_q;
      if (!cs_active) begin
         bit_cnt_d = 3'd0;
         rx_d      = 7'd0;
         tx_d      = 8'hFF;
         miso_d    = 1'b1;
      end else begin
         if (rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            rx_d      = {rx_q[5:0], do_s2_q};
         end
         // The fall after a byte's 8th rise drives the freshly loaded MSB
         if (fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b1};
         end
         if (tx_load) tx_d = tx_byte;
      end
   end
endmodule

// File: rtl/mmc_card_spi.sv
// mmc_card_spi: SPI-mode MMC/SD card responder.
//   Ports: clk, reset (async, active high), bus (mmc_card_spi_if.slave):
//   SPI link, byte-wide backing store port, card_idle and state_out.
//
//   state      | meaning
//   S_IDLE     | hunting for a 01xxxxxx command start byte
//   S_CMD      | collecting argument (4 bytes) and CRC
//   S_NCR      | 0xFF filler slots before R1
//   S_R1       | R1 response slot
//   S_RD_TOKEN | 0xFE start token slot
//   S_RD_DATA  | block read data slots
//   S_RD_CRC   | two 0xFF CRC slots
//   S_WR_WAIT  | discarding bytes until 0xFE
//   S_WR_DATA  | block write data, one mem_wr per byte
//   S_WR_CRC   | two discarded CRC bytes
//   S_WR_RESP  | 0x05 data-response slot
//   S_WR_BUSY  | busy 0x00 slots, then one 0xFF
module mmc_card_spi #(
   parameter int NCR        = 1,
   parameter int BUSY_BYTES = 4,
   parameter int BLOCK_LEN  = 512
) (
   input logic            clk,
   input logic            reset,
   mmc_card_spi_if.slave  bus
);
   import mmc_pkg::*;

   localparam logic [15:0] BLK_LAST  = 16'(BLOCK_LEN - 1);
   localparam logic [15:0] NCR_LAST  = (NCR > 0) ? 16'(NCR - 1) : 16'd0;
   localparam logic [15:0] BUSY_CNT  = 16'(BUSY_BYTES);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [5:0]  cmd_q, cmd_d;
   logic [31:0] arg_q, arg_d;
   logic [31:0] addr_q, addr_d;
   logic        idle_q, idle_d;
   logic        load_q;
   logic        cs_active, byte_done;
   logic [7:0]  rx_byte, tx_byte, r1;
   logic        rd_strobe, wr_strobe;

   mmc_spi_byte u_byte (
      .clk       (clk),
      .reset     (reset),
      .mmc_cs    (bus.mmc_cs),
      .mmc_sclk  (bus.mmc_sclk),
      .mmc_do    (bus.mmc_do),
      .tx_load   (load_q),
      .tx_byte   (tx_byte),
      .mmc_di    (bus.mmc_di),
      .cs_active (cs_active),
      .byte_done (byte_done),
      .rx_byte   (rx_byte)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         cmd_q   <= 6'd0;
         arg_q   <= 32'd0;
         addr_q  <= 32'd0;
         idle_q  <= 1'b1;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         arg_q   <= arg_d;
         addr_q  <= addr_d;
         idle_q  <= idle_d;
         load_q  <= byte_done;
      end
   end

   assign r1 = calc_r1(cmd_q, arg_q, idle_q, 32'(BLOCK_LEN));

   // The tx byte loads one cycle after byte_done, so it is chosen from the
   // state being entered; that cycle is also when mem_rdata is valid.
   always_comb begin
      case (state_q)
         S_R1:       tx_byte = r1;
         S_RD_TOKEN: tx_byte = TOKEN_START;
         S_RD_DATA:  tx_byte = bus.mem_rdata;
         S_WR_RESP:  tx_byte = TOKEN_DATA_ACC;
         S_WR_BUSY:  tx_byte = (cnt_q != 16'd0) ? BYTE_BUSY : BYTE_FILL;
         default:    tx_byte = BYTE_FILL;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      arg_d     = arg_q;
      addr_d    = addr_q;
      idle_d    = idle_q;
      rd_strobe = 1'b0;
      wr_strobe = 1'b0;
      if (!cs_active) begin
         state_d = S_IDLE;
         cnt_d   = 16'd0;
      end else if (byte_done) begin
         case (state_q)
            S_IDLE: if (rx_byte[7:6] == 2'b01) begin
               cmd_d   = rx_byte[5:0];
               cnt_d   = 16'd4;
               state_d = S_CMD;
            end
            S_CMD: if (cnt_q != 16'd0) begin
               arg_d = {arg_q[23:0], rx_byte};
               cnt_d = cnt_q - 16'd1;
            end else if (NCR == 0) begin
               state_d = S_R1;
            end else begin
               cnt_d   = NCR_LAST;
               state_d = S_NCR;
            end
            S_NCR: if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                   else state_d = S_R1;
            S_R1: begin
               if (cmd_q == CMD0) idle_d = 1'b1;
               if (cmd_q == CMD1) idle_d = 1'b0;
               addr_d  = arg_q;
               state_d = S_IDLE;
               if (r1 == R1_READY && cmd_q == CMD17) state_d = S_RD_TOKEN;
               if (r1 == R1_READY && cmd_q == CMD24) state_d = S_WR_WAIT;
            end
            // Each read strobe fetches the byte for the following slot
            S_RD_TOKEN: begin
               rd_strobe = 1'b1;
               addr_d    = addr_q + 32'd1;
               cnt_d     = BLK_LAST;
               state_d   = S_RD_DATA;
            end
            S_RD_DATA: if (cnt_q != 16'd0) begin
               rd_strobe = 1'b1;
               addr_d    = addr_q + 32'd1;
               cnt_d     = cnt_q - 16'd1;
            end else begin
               cnt_d   = 16'd1;
               state_d = S_RD_CRC;
            end
            S_RD_CRC: if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                      else state_d = S_IDLE;
            S_WR_WAIT: if (rx_byte == TOKEN_START) begin
               cnt_d   = BLK_LAST;
               state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
               wr_strobe = 1'b1;
               addr_d    = addr_q + 32'd1;
               if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
               else begin
                  cnt_d   = 16'd1;
                  state_d = S_WR_CRC;
               end
            end
            S_WR_CRC: if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                      else state_d = S_WR_RESP;
            S_WR_RESP: begin
               cnt_d   = BUSY_CNT;
               state_d = S_WR_BUSY;
            end
            S_WR_BUSY: if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                       else state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_rd    = rd_strobe;
   assign bus.mem_wr    = wr_strobe;
   assign bus.mem_wdata = wr_strobe ? rx_byte : 8'h00;
   assign bus.card_idle = idle_q;
   assign bus.state_out = state_q;
endmodule

// File: tb/tb_mmc_card_spi.sv
module tb_mmc_card_spi;
   import mmc_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mmc_card_spi_if bus();

   mmc_card_spi #(.NCR(1), .BUSY_BYTES(4), .BLOCK_LEN(512)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] mem [0:4095];
   logic [7:0] rdata_q;
   always @(posedge clk) begin
      if (bus.mem_rd) rdata_q <= mem[bus.mem_addr[11:0]];
      if (bus.mem_wr) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
   end
   assign bus.mem_rdata = rdata_q;

   int vectors = 0;
   int miscompares = 0;
   int rd_count = 0;
   logic [7:0]  exp_miso_q[$];
   logic [39:0] exp_wr_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // MISO monitor: assembles bytes on host sampling edges
   initial begin : miso_mon
      int mbit;
      logic [7:0] msh;
      mbit = 0;
      msh  = 8'h00;
      forever begin
         @(posedge bus.mmc_sclk or posedge bus.mmc_cs);
         if (bus.mmc_cs) mbit = 0;
         else begin
            msh = {msh[6:0], bus.mmc_di};
            mbit++;
            if (mbit == 8) begin
               mbit = 0;
               if (exp_miso_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL miso_extra: got %0h with nothing expected", msh);
               end else check("miso_byte", msh, exp_miso_q.pop_front());
            end
         end
      end
   end

   // Memory-port monitor
   initial begin : mem_mon
      forever begin
         @(negedge clk);
         if (bus.mem_rd === 1'b1) rd_count++;
         if (bus.mem_wr === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL mem_wr_extra: addr %0h data %0h", bus.mem_addr, bus.mem_wdata);
            end else check("mem_wr", {bus.mem_addr, bus.mem_wdata}, exp_wr_q.pop_front());
         end
      end
   end

   task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp);
      exp_miso_q.push_back(exp);
      for (int i = 7; i >= 0; i--) begin
         bus.mmc_do = tx[i];
         #40 bus.mmc_sclk = 1'b1;
         #40 bus.mmc_sclk = 1'b0;
      end
   endtask

   task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] r1);
      spi_byte({2'b01, idx}, 8'hFF);
      spi_byte(arg[31:24], 8'hFF);
      spi_byte(arg[23:16], 8'hFF);
      spi_byte(arg[15:8], 8'hFF);
      spi_byte(arg[7:0], 8'hFF);
      spi_byte(8'h95, 8'hFF);
      spi_byte(8'hFF, 8'hFF);
      spi_byte(8'hFF, r1);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_mmc_di"}, bus.mmc_di, 1'b1);
      check({tag, "_mem_rd"}, bus.mem_rd, 1'b0);
      check({tag, "_mem_wr"}, bus.mem_wr, 1'b0);
      check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 8'h00);
      check({tag, "_card_idle"}, bus.card_idle, 1'b1);
      check({tag, "_state"}, bus.state_out, 4'(S_IDLE));
   endtask

   initial begin
      bus.mmc_cs   = 1'b1;
      bus.mmc_sclk = 1'b0;
      bus.mmc_do   = 1'b1;
      reset        = 1'b1;
      rdata_q      = 8'h00;
      for (int a = 0; a < 4096; a++) mem[a] = 8'(a);
      #20 check_reset("por");
      #20 reset = 1'b0;
      #40;
      repeat (80) begin
         #40 bus.mmc_sclk = 1'b1;
         #40 bus.mmc_sclk = 1'b0;
      end
      check("preamble_state", bus.state_out, 4'(S_IDLE));
      #40 bus.mmc_cs = 1'b0;
      #40;

      cmd(CMD0, 32'h0, 8'h01);
      check("cmd0_idle", bus.card_idle, 1'b1);

      rd_count = 0;
      cmd(CMD17, 32'h400, 8'h05);
      spi_byte(8'hFF, 8'hFF);
      spi_byte(8'hFF, 8'hFF);
      check("cmd17_idle_no_rd", rd_count, 0);

      cmd(CMD1, 32'h0, 8'h00);
      check("cmd1_idle", bus.card_idle, 1'b0);
      cmd(CMD16, 32'h200, 8'h00);
      cmd(CMD16, 32'h100, 8'h40);
      cmd(6'd55, 32'h0, 8'h04);

      // Block read; a start byte sent mid-block must be ignored
      rd_count = 0;
      cmd(CMD17, 32'h400, 8'h00);
      spi_byte(8'hFF, 8'hFE);
      for (int i = 0; i < 512; i++) spi_byte((i == 5) ? 8'h40 : 8'hFF, 8'(i));
      spi_byte(8'hFF, 8'hFF);
      spi_byte(8'hFF, 8'hFF);
      check("read_rd_count", rd_count, 512);
      check("read_end_state", bus.state_out, 4'(S_IDLE));

      // Block write
      cmd(CMD24, 32'h800, 8'h00);
      spi_byte(8'hFF, 8'hFF);
      spi_byte(8'hFF, 8'hFF);
      spi_byte(8'hFE, 8'hFF);
      for (int i = 0; i < 512; i++) begin
         exp_wr_q.push_back({32'h800 + 32'(i), 8'hA5});
         spi_byte(8'hA5, 8'hFF);
      end
      spi_byte(8'h12, 8'hFF);
      spi_byte(8'h34, 8'hFF);
      spi_byte(8'hFF, 8'h05);
      repeat (4) spi_byte(8'hFF, 8'h00);
      spi_byte(8'hFF, 8'hFF);
      check("write_wr_pending", exp_wr_q.size(), 0);
      check("write_mem_last", mem[12'h9FF], 8'hA5);
      check("write_mem_beyond", mem[12'hA00], 8'h00);

      // CS abort mid-read
      rd_count = 0;
      cmd(CMD17, 32'h400, 8'h00);
      spi_byte(8'hFF, 8'hFE);
      for (int i = 0; i < 10; i++) spi_byte(8'hFF, 8'(i));
      #40 bus.mmc_cs = 1'b1;
      #60;
      check("abort_mmc_di", bus.mmc_di, 1'b1);
      check("abort_state", bus.state_out, 4'(S_IDLE));
      check("abort_rd_count", rd_count, 11);
      bus.mmc_cs = 1'b0;
      #40;
      cmd(CMD0, 32'h0, 8'h01);
      check("abort_cmd0_idle", bus.card_idle, 1'b1);
      cmd(CMD1, 32'h0, 8'h00);

      // Async reset mid-write
      cmd(CMD24, 32'h800, 8'h00);
      spi_byte(8'hFF, 8'hFF);
      spi_byte(8'hFE, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         exp_wr_q.push_back({32'h800 + 32'(i), 8'h3C});
         spi_byte(8'h3C, 8'hFF);
      end
      #23;
      check("prereset_state", bus.state_out, 4'(S_WR_DATA));
      check("prereset_addr", bus.mem_addr, 32'h803);
      reset = 1'b1;
      #1 check_reset("midwrite");
      #20 bus.mmc_cs = 1'b1;
      #20 reset = 1'b0;
      #30;
      check("final_miso_pending", exp_miso_q.size(), 0);
      check("final_wr_pending", exp_wr_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
